servo_pwm_decoder: RTL and testbench

SERVO_PWM_DECODER -- requirements
Module: servo_pwm_decoder

---
 rtl/servo_pkg.sv | 40 ++++
 rtl/pwm_edge_sync.sv | 34 +++
 rtl/servo_pwm_decoder.sv | 161 ++++++++++++++++
 tb/tb_servo_pwm_decoder.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// Shared constants, FSM state type and frame classification for the servo PWM decoder.
package servo_pkg;

  localparam int WIDTH_W  = 12;
  localparam int PERIOD_W = 15;
  localparam int POS_W    = 8;
  localparam int IDLE_W   = 15;

  localparam logic [PERIOD_W-1:0] FRAME_MIN = 15'd19000;
  localparam logic [PERIOD_W-1:0] FRAME_MAX = 15'd21000;
  localparam logic [WIDTH_W-1:0]  PW_MIN    = 12'd500;
  localparam logic [WIDTH_W-1:0]  PW_MAX    = 12'd2200;
  localparam logic [IDLE_W-1:0]   TIMEOUT   = 15'd25000;

  typedef enum logic [1:0] {
    ST_SYNC,
    ST_ARMED,
    ST_HIGH,
    ST_LOW
  } state_e;

  typedef enum logic [1:0] {
    FRAME_OK,
    FRAME_BAD_WIDTH,
    FRAME_BAD_PERIOD
  } frame_res_e;

  // Period is judged before width; saturated counts fall outside both windows.
  function automatic frame_res_e classify_frame(
    input logic [PERIOD_W-1:0] period,
    input logic [WIDTH_W-1:0]  width,
    input logic [PERIOD_W-1:0] fmin,
    input logic [PERIOD_W-1:0] fmax
  );
    if (period < fmin || period > fmax) return FRAME_BAD_PERIOD;
    if (width < PW_MIN || width > PW_MAX) return FRAME_BAD_WIDTH;
    return FRAME_OK;
  endfunction

endpackage

// File: rtl/pwm_edge_sync.sv
// Two-flop synchronizer for the raw PWM line plus rise/fall detection on the
// synchronized level.
module pwm_edge_sync (
  input  logic mclk,
  input  logic rst_n,
  input  logic i_pwm,
  output logic o_pwm_s,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_pwm_s;
  logic r_pwm_d;

  // NOTE: non-blocking assignments make every stage take its neighbour's old
  // value; blocking ones would collapse the chain into a single flop.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta  <= 1'b0;
      r_pwm_s <= 1'b0;
      r_pwm_d <= 1'b0;
    end else begin
      r_meta  <= i_pwm;
      r_pwm_s <= r_meta;
      r_pwm_d <= r_pwm_s;
    end
  end

  assign o_pwm_s = r_pwm_s;
  assign o_rise  = r_pwm_s & ~r_pwm_d;
  assign o_fall  = ~r_pwm_s & r_pwm_d;

endmodule

// File: rtl/servo_pwm_decoder.sv
// Measures servo PWM high time and frame period, reports accepted positions or
// rejection strobes, and flags a dead line.
module servo_pwm_decoder
  import servo_pkg::*;
#(
  parameter logic [PERIOD_W-1:0] P_FRAME_MIN = FRAME_MIN,
  parameter logic [PERIOD_W-1:0] P_FRAME_MAX = FRAME_MAX,
  parameter logic [IDLE_W-1:0]   P_TIMEOUT   = TIMEOUT
) (
  input  logic               mclk,
  input  logic               rst_n,
  input  logic               pwm_in,
  output logic [WIDTH_W-1:0] width_us,
  output logic [POS_W-1:0]   position,
  output logic               pos_valid,
  output logic               err_width,
  output logic               err_period,
  output logic               timeout
);

  logic w_pwm_s;
  logic w_rise;
  logic w_fall;

  pwm_edge_sync u_edge_sync (
    .mclk    (mclk),
    .rst_n   (rst_n),
    .i_pwm   (pwm_in),
    .o_pwm_s (w_pwm_s),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  state_e              r_state;
  logic [WIDTH_W-1:0]  r_width_cnt;
  logic [PERIOD_W-1:0] r_period_cnt;
  logic [3:0]          r_presc;
  logic [POS_W-1:0]    r_tens;
  logic [WIDTH_W-1:0]  r_cand_width;
  logic [POS_W-1:0]    r_cand_pos;
  logic [IDLE_W-1:0]   r_idle_cnt;
  logic [1:0]          r_settle;

  logic [WIDTH_W-1:0]  w_width_inc;
  logic [PERIOD_W-1:0] w_period_inc;
  logic [POS_W-1:0]    w_tens_inc;
  logic [POS_W-1:0]    w_cand_pos;
  logic                w_settled;
  logic                w_idle_expire;
  frame_res_e          w_res;

  assign w_width_inc  = (r_width_cnt == '1) ? r_width_cnt : r_width_cnt + WIDTH_W'(1);
  assign w_period_inc = (r_period_cnt == '1) ? r_period_cnt : r_period_cnt + PERIOD_W'(1);
  assign w_tens_inc   = (r_tens == '1) ? r_tens : r_tens + POS_W'(1);

  // The tally holds width_cnt in decades; the latched width is one more, which
  // only crosses a decade when the prescaler sits at 9.
  assign w_cand_pos = (r_presc == 4'd9) ? w_tens_inc : r_tens;

  assign w_settled     = (r_settle == 2'd2);
  assign w_idle_expire = !(w_rise || w_fall) && (r_idle_cnt == P_TIMEOUT - IDLE_W'(1));
  assign w_res         = classify_frame(w_period_inc, r_cand_width, P_FRAME_MIN, P_FRAME_MAX);

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_SYNC;
      r_width_cnt  <= '0;
      r_period_cnt <= '0;
      r_presc      <= '0;
      r_tens       <= '0;
      r_cand_width <= '0;
      r_cand_pos   <= '0;
      r_idle_cnt   <= '0;
      r_settle     <= '0;
      width_us     <= '0;
      position     <= '0;
      pos_valid    <= 1'b0;
      err_width    <= 1'b0;
      err_period   <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      pos_valid  <= 1'b0;
      err_width  <= 1'b0;
      err_period <= 1'b0;

      if (w_rise || w_fall)
        r_idle_cnt <= '0;
      else if (r_idle_cnt != P_TIMEOUT)
        r_idle_cnt <= r_idle_cnt + IDLE_W'(1);

      if (!w_settled)
        r_settle <= r_settle + 2'd1;

      if (w_idle_expire) begin
        timeout <= 1'b1;
        r_state <= ST_SYNC;
      end else begin
        case (r_state)
          // Synchronizer reset values are not line samples; wait for them to
          // flush so a pulse already in progress at reset is never measured.
          ST_SYNC: begin
            if (w_settled && !w_pwm_s)
              r_state <= ST_ARMED;
          end

          ST_ARMED: begin
            if (w_rise) begin
              r_width_cnt  <= '0;
              r_period_cnt <= '0;
              r_presc      <= '0;
              r_tens       <= '0;
              r_state      <= ST_HIGH;
            end
          end

          ST_HIGH: begin
            r_period_cnt <= w_period_inc;
            if (w_fall) begin
              r_cand_width <= w_width_inc;
              r_cand_pos   <= w_cand_pos;
              r_state      <= ST_LOW;
            end else begin
              r_width_cnt <= w_width_inc;
              if (r_presc == 4'd9) begin
                r_presc <= '0;
                r_tens  <= w_tens_inc;
              end else begin
                r_presc <= r_presc + 4'd1;
              end
            end
          end

          ST_LOW: begin
            if (w_rise) begin
              case (w_res)
                FRAME_OK: begin
                  width_us  <= r_cand_width;
                  position  <= r_cand_pos;
                  pos_valid <= 1'b1;
                  timeout   <= 1'b0;
                end
                FRAME_BAD_WIDTH: err_width  <= 1'b1;
                default:         err_period <= 1'b1;
              endcase
              r_width_cnt  <= '0;
              r_period_cnt <= '0;
              r_presc      <= '0;
              r_tens       <= '0;
              r_state      <= ST_HIGH;
            end else begin
              r_period_cnt <= w_period_inc;
            end
          end

          default: r_state <= ST_SYNC;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Drives servo PWM waveforms as level/duration segments and compares every
// strobe against a frame-level reference model; frame and timeout limits are shortened.
module tb_servo_pwm_decoder;

  localparam int FMIN = 2400;
  localparam int FMAX = 2600;
  localparam int TMO  = 3000;
  localparam int NOM  = 2500;
  localparam int PWLO = 500;
  localparam int PWHI = 2200;

  logic        mclk = 1'b0;
  logic        rst_n;
  logic        pwm_in;
  logic [11:0] width_us;
  logic [7:0]  position;
  logic        pos_valid;
  logic        err_width;
  logic        err_period;
  logic        timeout;

  servo_pwm_decoder #(
    .P_FRAME_MIN (15'd2400),
    .P_FRAME_MAX (15'd2600),
    .P_TIMEOUT   (15'd3000)
  ) dut (
    .mclk       (mclk),
    .rst_n      (rst_n),
    .pwm_in     (pwm_in),
    .width_us   (width_us),
    .position   (position),
    .pos_valid  (pos_valid),
    .err_width  (err_width),
    .err_period (err_period),
    .timeout    (timeout)
  );

  always #5 mclk = ~mclk;

  longint cyc = 0;
  always @(posedge mclk) cyc <= cyc + 1;

  typedef struct {
    int     kind;   // 0 accepted, 1 width error, 2 period error
    int     width;
    int     pos;
    longint cyc;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  // Reference model: line runs, rise-to-rise periods and high runs.
  bit     m_level, m_sync_ok, m_have_prev, m_timed, m_timeout;
  int     m_run, m_last_high, m_width, m_pos;
  longint m_last_rise;

  task automatic model_reset(input bit line);
    m_level     = line;
    m_sync_ok   = !line;
    m_have_prev = 1'b0;
    m_timed     = 1'b0;
    m_timeout   = 1'b0;
    m_run       = 0;
    m_last_high = 0;
    m_width     = 0;
    m_pos       = 0;
    m_last_rise = 0;
  endtask

  task automatic model_eval(input longint period, input int width, input longint at);
    ev_t    e;
    longint p;
    int     w;
    p = (period > 32767) ? 32767 : period;
    w = (width > 4095) ? 4095 : width;
    if (p < FMIN || p > FMAX) begin
      e.kind = 2;
    end else if (w < PWLO || w > PWHI) begin
      e.kind = 1;
    end else begin
      e.kind    = 0;
      m_width   = w;
      m_pos     = w / 10;
      m_timeout = 1'b0;
    end
    e.width = m_width;
    e.pos   = m_pos;
    e.cyc   = at;
    exp_q.push_back(e);
  endtask

  task automatic model_seg(input bit lvl, input int len, input longint start);
    if (lvl != m_level) begin
      if (lvl) begin
        if (m_sync_ok) begin
          // Strobe appears on the third edge counting the first sampling edge.
          if (m_have_prev) model_eval(start - m_last_rise, m_last_high, start + 2);
          m_have_prev = 1'b1;
          m_last_rise = start;
        end
      end else begin
        m_last_high = m_run;
        m_sync_ok   = 1'b1;
      end
      m_level = lvl;
      m_run   = 0;
      m_timed = 1'b0;
    end
    m_run += len;
    if (m_run > TMO && !m_timed) begin
      m_timed     = 1'b1;
      m_timeout   = 1'b1;
      m_have_prev = 1'b0;
      if (m_level) m_sync_ok = 1'b0;
    end
  endtask

  // Call only at a falling edge; holds the level for len sampling edges.
  task automatic drive_seg(input bit lvl, input int len);
    model_seg(lvl, len, cyc + 1);
    pwm_in = lvl;
    repeat (len) @(negedge mclk);
  endtask

  task automatic frame(input int high, input int period);
    drive_seg(1'b1, high);
    drive_seg(1'b0, period - high);
  endtask

  always @(negedge mclk) begin : monitor
    ev_t e;
    if (rst_n && (pos_valid || err_width || err_period)) begin
      check("strobe_onehot", 64'(int'(pos_valid) + int'(err_width) + int'(err_period)), 64'd1);
      e.kind  = pos_valid ? 0 : (err_width ? 1 : 2);
      e.width = int'(width_us);
      e.pos   = int'(position);
      e.cyc   = cyc;
      obs_q.push_back(e);
    end
  end

  task automatic compare_events(input string tag);
    int n;
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_kind%0d", tag, i),  obs_q[i].kind,  exp_q[i].kind);
      check($sformatf("%s_width%0d", tag, i), obs_q[i].width, exp_q[i].width);
      check($sformatf("%s_pos%0d", tag, i),   obs_q[i].pos,   exp_q[i].pos);
      check($sformatf("%s_cyc%0d", tag, i),   obs_q[i].cyc,   exp_q[i].cyc);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_width"},   width_us,   0);
    check({tag, "_pos"},     position,   0);
    check({tag, "_valid"},   pos_valid,  0);
    check({tag, "_errw"},    err_width,  0);
    check({tag, "_errp"},    err_period, 0);
    check({tag, "_timeout"}, timeout,    0);
  endtask

  initial begin
    rst_n  = 1'b0;
    pwm_in = 1'b0;
    model_reset(1'b0);
    repeat (3) @(negedge mclk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    drive_seg(1'b0, 100);

    // Nominal: three frames, reports on the 2nd and 3rd rises.
    for (int i = 0; i < 3; i++) frame(1500, NOM);
    compare_events("nominal");
    check("nominal_width", width_us, 1500);
    check("nominal_pos", position, 150);

    // Width boundary.
    frame(2200, NOM);
    frame(2201, NOM);
    frame(1500, NOM);
    compare_events("width_bound");

    // Period boundaries around the accepted window.
    frame(1500, FMIN - 1);
    frame(1500, FMIN);
    frame(1500, FMAX);
    frame(1500, FMAX + 1);
    frame(1500, NOM);
    compare_events("period_bound");

    // One-cycle glitch inside LOW.
    drive_seg(1'b1, 1500);
    drive_seg(1'b0, 600);
    drive_seg(1'b1, 1);
    drive_seg(1'b0, NOM - 1);
    frame(1500, NOM);
    compare_events("glitch");

    // Stuck-low line after a valid frame.
    frame(1700, NOM);
    drive_seg(1'b1, 1500);
    drive_seg(1'b0, TMO - 20);
    check("stuck_before", timeout, m_timeout);
    drive_seg(1'b0, 40);
    check("stuck_timeout", timeout, m_timeout);
    check("stuck_width_held", width_us, m_width);
    check("stuck_pos_held", position, m_pos);
    frame(1500, NOM);
    check("rearm_timeout", timeout, m_timeout);
    frame(1200, NOM);
    check("recover_timeout", timeout, m_timeout);
    compare_events("stuck");

    // Reset mid-pulse, released with the line still high.
    frame(1800, NOM);
    drive_seg(1'b1, 700);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midreset");
    model_reset(1'b1);
    repeat (5) @(negedge mclk);
    rst_n = 1'b1;
    drive_seg(1'b1, 600);
    drive_seg(1'b0, 1800);
    frame(1500, NOM);
    frame(1300, NOM);
    compare_events("startup");

    // Randomized frames around both windows.
    for (int i = 0; i < 6; i++) begin
      int h, p;
      h = $urandom_range(2250, 400);
      p = $urandom_range(FMAX + 100, FMIN - 100);
      frame(h, p);
    end
    drive_seg(1'b1, 1500);
    drive_seg(1'b0, 200);
    compare_events("random");
    check("final_width", width_us, m_width);
    check("final_pos", position, m_pos);
    check("final_timeout", timeout, m_timeout);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
